// File: rtl/lfsr_period_checker.sv
// Measures the period of a monitored LFSR: captures a seed, counts steps until it recurs,
// and flags stuck (no change between samples) or runaway (no recurrence in 2^WIDTH steps).
module lfsr_period_checker #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [WIDTH-1:0]   i_lfsr_in,
   input  logic               i_sample_en,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_result_valid,
   output logic [WIDTH:0]     o_period,
   output logic               o_fault,
   output logic [1:0]         o_fault_code
);

   localparam int unsigned CNT_W = WIDTH + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {WIDTH{1'b0}}};
   localparam logic [1:0] FAULT_STUCK   = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {StIdle, StArm, StCount, StDone, StFault} state_e;

   state_e             r_state;
   logic [WIDTH-1:0]   r_seed;
   logic [WIDTH-1:0]   r_prev;
   logic [CNT_W-1:0]   r_count;
   logic               r_busy;
   logic               r_result_valid;
   logic [CNT_W-1:0]   r_period;
   logic               r_fault;
   logic [1:0]         r_fault_code;
   logic [CNT_W-1:0]   w_next;

   assign w_next = r_count + CNT_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= StIdle;
         r_seed         <= '0;
         r_prev         <= '0;
         r_count        <= '0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_period       <= '0;
         r_fault        <= 1'b0;
         r_fault_code   <= 2'b00;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_state <= StArm;
                  r_busy  <= 1'b1;
               end
            end
            StArm: begin
               if (i_sample_en) begin
                  r_seed  <= i_lfsr_in;
                  r_prev  <= i_lfsr_in;
                  r_count <= '0;
                  r_state <= StCount;
               end
            end
            StCount: begin
               // Stuck is tested before the seed match, so period-1 sequences report STUCK.
               if (i_sample_en) begin
                  if (i_lfsr_in == r_prev) begin
                     r_state      <= StFault;
                     r_busy       <= 1'b0;
                     r_fault      <= 1'b1;
                     r_fault_code <= FAULT_STUCK;
                  end else if (i_lfsr_in == r_seed) begin
                     r_state        <= StDone;
                     r_busy         <= 1'b0;
                     r_result_valid <= 1'b1;
                     r_period       <= w_next;
                  end else if (w_next == MAX_CNT) begin
                     r_state      <= StFault;
                     r_busy       <= 1'b0;
                     r_fault      <= 1'b1;
                     r_fault_code <= FAULT_TIMEOUT;
                  end else begin
                     r_count <= w_next;
                     r_prev  <= i_lfsr_in;
                  end
               end
            end
            StDone: begin
               if (i_start) begin
                  r_state        <= StArm;
                  r_busy         <= 1'b1;
                  r_result_valid <= 1'b0;
                  r_period       <= '0;
               end
            end
            StFault: begin
               if (i_start) begin
                  r_state      <= StArm;
                  r_busy       <= 1'b1;
                  r_fault      <= 1'b0;
                  r_fault_code <= 2'b00;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_busy         = r_busy;
   assign o_result_valid = r_result_valid;
   assign o_period       = r_period;
   assign o_fault        = r_fault;
   assign o_fault_code   = r_fault_code;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Randomised self-checking bench for lfsr_period_checker against a sequence-level outcome model.
module tb_lfsr_period_checker;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [3:0] i_lfsr_in = '0;
   logic       i_sample_en = 1'b0;
   logic       i_start = 1'b0;
   logic       o_busy;
   logic       o_result_valid;
   logic [4:0] o_period;
   logic       o_fault;
   logic [1:0] o_fault_code;

   int checks = 0;
   int errors = 0;
   logic [3:0] seq[$];

   always #5 clk = ~clk;

   lfsr_period_checker #(.WIDTH(4)) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_lfsr_in      (i_lfsr_in),
      .i_sample_en    (i_sample_en),
      .i_start        (i_start),
      .o_busy         (o_busy),
      .o_result_valid (o_result_valid),
      .o_period       (o_period),
      .o_fault        (o_fault),
      .o_fault_code   (o_fault_code)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outcome of a sampled sequence: kind 0 done, 1 stuck, 2 timeout, -1 undecided.
   function automatic void model(output int kind, output int per, output int last);
      kind = -1; per = 0; last = 0;
      for (int k = 1; k < seq.size(); k++) begin
         last = k;
         if (seq[k] == seq[k-1]) begin kind = 1; return; end
         if (seq[k] == seq[0]) begin kind = 0; per = k; return; end
         if (k == 16) begin kind = 2; return; end
      end
   endfunction

   task automatic load_maximal();
      int vals[16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
      seq.delete();
      foreach (vals[i]) seq.push_back(4'(vals[i]));
   endtask

   task automatic check_outputs(input string name, input logic busy, input logic rv,
                                input logic [4:0] per, input logic flt, input logic [1:0] code);
      checks++;
      if ({o_busy, o_result_valid, o_period, o_fault, o_fault_code} !==
          {busy, rv, per, flt, code}) begin
         errors++;
         $display("FAIL %s: got busy=%0b rv=%0b period=%0d fault=%0b code=%0d want busy=%0b rv=%0b period=%0d fault=%0b code=%0d",
                  name, o_busy, o_result_valid, o_period, o_fault, o_fault_code,
                  busy, rv, per, flt, code);
      end
   endtask

   // Starts a measurement and feeds seq, with gaps of idle sample_en cycles between samples.
   task automatic run_seq(input string name, input int gap_max, input bit rnd_gap,
                          input bit mid_start);
      int kind, per, last, g;
      logic [1:0] code;
      model(kind, per, last);
      i_start = 1'b1;
      i_sample_en = 1'($urandom_range(0, 1));
      tick();
      i_start = 1'b0;
      i_sample_en = 1'b0;
      check_outputs({name, " armed"}, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0);
      for (int k = 0; k <= last; k++) begin
         g = rnd_gap ? $urandom_range(0, gap_max) : gap_max;
         for (int j = 0; j < g; j++) begin
            if (mid_start && j == 0) i_start = 1'b1;
            tick();
            i_start = 1'b0;
            checks++;
            if ({o_busy, o_result_valid, o_fault} !== 3'b100) begin
               errors++;
               $display("FAIL %s gap k=%0d: got busy/rv/fault=%b want 100", name, k,
                        {o_busy, o_result_valid, o_fault});
            end
         end
         i_lfsr_in = seq[k];
         i_sample_en = 1'b1;
         tick();
         i_sample_en = 1'b0;
         if (k < last) begin
            checks++;
            if ({o_busy, o_result_valid, o_fault} !== 3'b100) begin
               errors++;
               $display("FAIL %s step k=%0d: got busy/rv/fault=%b want 100", name, k,
                        {o_busy, o_result_valid, o_fault});
            end
         end
      end
      code = (kind == 1) ? 2'd1 : (kind == 2) ? 2'd2 : 2'd0;
      check_outputs({name, " result"}, 1'b0, kind == 0, (kind == 0) ? 5'(per) : 5'd0,
                    kind != 0, code);
      for (int h = 0; h < 2; h++) begin
         i_lfsr_in = 4'($urandom);
         i_sample_en = 1'($urandom_range(0, 1));
         tick();
         check_outputs({name, " held"}, 1'b0, kind == 0, (kind == 0) ? 5'(per) : 5'd0,
                       kind != 0, code);
      end
      i_sample_en = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_start = 1'b1;
      i_sample_en = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         check_outputs("reset", 1'b0, 1'b0, 5'd0, 1'b0, 2'd0);
      end
      i_reset = 1'b0;
      i_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         i_lfsr_in = 4'($urandom);
         tick();
         check_outputs("idle ignores sample_en", 1'b0, 1'b0, 5'd0, 1'b0, 2'd0);
      end
      i_sample_en = 1'b0;
   endtask

   task automatic test_maximal();
      load_maximal();
      run_seq("maximal", 0, 1'b0, 1'b0);
   endtask

   task automatic test_lockup();
      seq.delete();
      seq.push_back(4'd0);
      seq.push_back(4'd0);
      run_seq("lockup", 0, 1'b0, 1'b0);
   endtask

   task automatic test_runaway();
      seq.delete();
      for (int v = 1; v <= 15; v++) seq.push_back(4'(v));
      seq.push_back(4'd0);
      seq.push_back(4'd2);
      run_seq("runaway", 0, 1'b0, 1'b0);
   endtask

   task automatic test_gapped();
      load_maximal();
      run_seq("gapped", 3, 1'b0, 1'b1);
   endtask

   task automatic test_abort();
      load_maximal();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         i_lfsr_in = seq[k];
         i_sample_en = 1'b1;
         tick();
      end
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      i_sample_en = 1'b0;
      check_outputs("abort reset", 1'b0, 1'b0, 5'd0, 1'b0, 2'd0);
      run_seq("rerun", 0, 1'b0, 1'b0);
      run_seq("restart from done", 1, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int kind, per, last, range;
      for (int it = 0; it < 25; it++) begin
         range = (it % 3 == 0) ? 1 : (it % 3 == 1) ? 3 : 15;
         seq.delete();
         seq.push_back(4'($urandom_range(0, range)));
         do begin
            seq.push_back(4'($urandom_range(0, range)));
            model(kind, per, last);
         end while (kind < 0);
         run_seq("random", 2, 1'b1, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_maximal();
      test_lockup();
      test_runaway();
      test_gapped();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
